// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for the CPU datapath. It walks each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and emits
// one-cycle stage enables for the datapath. It also provides:
//   - req/ack handshakes to instruction and data memory
//   - run/halt control
//   - a wait-state watchdog
//   - an instruction retire counter
//
// Parameters
//   PC_W     program counter / branch target width
//   TIMEOUT  maximum cycles spent waiting for imem_ack / dmem_ack before the
//            sequencer enters ERROR; 0 disables the watchdog
//   CNT_W    width of instr_count
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   run            start from IDLE / resume from HALT (level)
//   halt_req       stop at the next instruction boundary
//   imem_req       instruction fetch request (whole FETCH state)
//   imem_ack       instruction valid this cycle
//   ir_load        latch instruction register (FETCH with ack)
//   pc             fetch address
//   decode_en      latch decoder outputs
//   opcode         registered opcode (0 LOAD, 1 STORE, 2-7 ALU)
//   alu_en         latch ALU result
//   branch_taken   ALU change-pc flag, valid in EXEC
//   branch_target  target address, valid in EXEC
//   dmem_req       data memory request (whole MEM state)
//   dmem_we        data memory write qualifier (STORE in MEM)
//   dmem_ack       data memory transfer complete
//   rf_we          register file write enable
//   busy           high in FETCH/DECODE/EXEC/MEM/WB
//   halted         high in HALT
//   err            sticky watchdog error (cleared only by reset)
//   instr_count    retired instruction count (wraps)
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  output logic [PC_W-1:0]  pc,
  output logic             decode_en,
  input  logic [2:0]       opcode,
  output logic             alu_en,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;

  // Wide enough to hold TIMEOUT-1; a disabled watchdog keeps one idle bit.
  localparam int WD_W = $clog2(TIMEOUT + 2);
  localparam bit WD_ON = (TIMEOUT != 0);

  state_t          state;
  state_t          state_nx;
  logic [WD_W-1:0] wd_cnt;
  logic            halt_pend;
  logic            retire;
  logic            wd_wait;
  logic            wd_expire;

  // The waiting cycle that would bring the count to TIMEOUT is the last one
  // allowed; an ack arriving in that same cycle still wins.
  assign wd_expire = WD_ON && (wd_cnt == WD_W'(TIMEOUT - 1));

  assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                  (state == S_MEM)   || (state == S_WB);
  assign halted = (state == S_HALT);
  // ERROR is only left through reset, so the state itself is the sticky flag.
  assign err    = (state == S_ERROR);

  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    decode_en = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    wd_wait   = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_nx = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load  = 1'b1;
          state_nx = S_DECODE;
        end else begin
          wd_wait = 1'b1;
          if (wd_expire) state_nx = S_ERROR;
        end
      end

      S_DECODE: begin
        decode_en = 1'b1;
        state_nx  = S_EXEC;
      end

      S_EXEC: begin
        alu_en = 1'b1;
        if (branch_taken) begin
          // Taken branches skip WB and retire straight from EXEC.
          retire = 1'b1;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) retire = 1'b1;
          else                    state_nx = S_WB;
        end else begin
          wd_wait = 1'b1;
          if (wd_expire) state_nx = S_ERROR;
        end
      end

      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end

      S_HALT: begin
        // run wins over a simultaneous halt_req.
        if (run) state_nx = S_FETCH;
      end

      S_ERROR: begin
        state_nx = S_ERROR;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Instruction boundary: either return to FETCH or honour a halt request
    // that arrived at any point during this instruction.
    if (retire) state_nx = (halt_req || halt_pend) ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= '0;
      wd_cnt      <= '0;
      halt_pend   <= 1'b0;
    end else begin
      state <= state_nx;

      // Branch target in EXEC overrides the increment done at fetch.
      if ((state == S_EXEC) && branch_taken) pc <= branch_target;
      else if (ir_load)                       pc <= pc + PC_W'(1);

      if (retire) instr_count <= instr_count + CNT_W'(1);

      // Every exit from FETCH/MEM happens on an ack (or into ERROR), so
      // clearing whenever not waiting also clears on each new entry.
      if (wd_wait && WD_ON) wd_cnt <= wd_cnt + WD_W'(1);
      else                  wd_cnt <= '0;

      // halt_req is remembered while an instruction is in flight and acted
      // on at retirement; outside busy states it is ignored.
      if (state_nx == S_HALT)     halt_pend <= 1'b0;
      else if (busy && halt_req)  halt_pend <= 1'b1;
    end
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the CPU datapath (program counter, instruction register, decoder, ALU, register file, data memory).
- Replaces the datapath's free-running 4-step state counter.
- Adds four things: req/ack handshakes to instruction and data memory, run/halt control, a wait-state watchdog, and an instruction retire counter.
- Emits one-cycle stage enables consumed by the datapath.

Parameters:
PC_W, 8, program counter / branch target width
TIMEOUT, 64, maximum cycles waiting for imem_ack or dmem_ack before error; 0 disables watchdog
CNT_W, 16, width of instr_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start from IDLE / resume from HALT (level, sampled)
halt_req  in  1  stop at next instruction boundary
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction valid this cycle
ir_load  out  1  latch instruction register
pc  out  PC_W  fetch address
decode_en  out  1  latch decoder outputs
opcode  in  3  registered opcode from decoder (0 LOAD, 1 STORE, 2-7 ALU)
alu_en  out  1  latch ALU result
branch_taken  in  1  ALU change-pc flag, valid in EXEC
branch_target  in  PC_W  target address, valid in EXEC
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write strobe qualifier
dmem_ack  in  1  data memory transfer complete
rf_we  out  1  register file write enable
busy  out  1  high in FETCH/DECODE/EXEC/MEM/WB
halted  out  1  high in HALT
err  out  1  sticky watchdog error
instr_count  out  CNT_W  retired instruction count

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, pc = 0, instr_count = 0, err = 0, watchdog counter = 0.
  - All strobes low.
  - Reset mid-transaction aborts immediately; no completion pulse is emitted.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR. All outputs decode combinationally from state plus the inputs listed below.
- IDLE:
  - Outputs all low.
  - run=1 moves to FETCH next cycle.
- FETCH:
  - imem_req=1 for the whole state.
  - On a cycle with imem_ack=1: ir_load=1 that cycle, pc <= pc+1 (wraps modulo 2^PC_W), next state DECODE.
  - Ack may arrive in the same cycle as the request (zero wait states).
- DECODE: decode_en=1 for one cycle, then EXEC.
- EXEC:
  - alu_en=1 for one cycle.
  - If branch_taken=1: pc <= branch_target (overrides the FETCH increment) and WB is skipped; the instruction retires and the next state is FETCH.
  - Otherwise: opcode 0/1 goes to MEM; opcode 2-7 goes to WB.
- MEM:
  - dmem_req=1 held until dmem_ack; dmem_we = (opcode==1).
  - On ack: LOAD goes to WB; STORE retires and goes to FETCH.
- WB: rf_we=1 for one cycle, instruction retires, next state FETCH.
- Retirement:
  - instr_count increments by 1 (wraps).
  - If halt_req=1 in the retire cycle, next state is HALT instead of FETCH.
  - halt_req at any other time is ignored until the next retirement; halt_req in IDLE is ignored.
- HALT: halted=1; run=1 resumes at FETCH with pc preserved. If run and halt_req are both high, run wins.
- Watchdog:
  - Counter clears on entry to FETCH or MEM.
  - Counter increments each cycle in those states while the ack is low.
  - If the counter reaches TIMEOUT with the ack still low: next state ERROR, err=1.
  - An ack in the same cycle the count hits TIMEOUT wins; no error.
- ERROR: all strobes low; err stays 1 until reset. The run input is ignored.
- Latency, zero-wait memories:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Taken branch: 3 cycles.
  - Each cycle of ack delay adds 1.
- Invariants:
  - At most one of ir_load, decode_en, alu_en, dmem_req, rf_we is high in any cycle.
  - imem_req and dmem_req are never both high.

Test Plan:
- Reset, run=1, zero-wait acks, ALU opcode 2 stream:
  - Required: ir_load, decode_en, alu_en, rf_we pulse on consecutive cycles.
  - Required: pc 0→1 on the ack cycle; instr_count=3 after 12 cycles.
- LOAD with dmem_ack delayed 3 cycles:
  - Required: dmem_req high 4 cycles with dmem_we=0.
  - Required: rf_we one cycle after the ack; total 8 cycles.
- STORE, zero-wait: dmem_we=1 during MEM, no rf_we; retire in 4 cycles.
- EXEC with branch_taken=1, branch_target=8'hF0 at pc=5:
  - Required: no rf_we; next FETCH drives pc=F0.
  - Required: FETCH at pc=FF wraps to pc=00.
- halt_req pulsed during DECODE:
  - Required: enters HALT after that instruction retires, halted=1.
  - Required: run=1 resumes FETCH at the preserved pc.
- TIMEOUT=4 with imem_ack held low:
  - Required: err=1 and ERROR entered after 4 waiting cycles; run ignored.
  - Required: rst_n low clears err, pc=0, state IDLE asynchronously.
